// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-to-decode valid/ready beat carrying {pc,instr}
interface instruction_fetch_unit_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  modport master (output out_valid, out_instr, out_pc, input out_ready);
  modport slave  (input out_valid, out_instr, out_pc, output out_ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: ROM-reading fetch PC with 2-entry prefetch FIFO, redirect flush and halt sentinel
module instruction_fetch_unit #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          HALT_EN   = 1'b1,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         addra,
  input  logic [31:0]               douta,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  instruction_fetch_unit_if.master  dec,
  output logic                      halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic        r_rd, r_wr;
  logic [31:0] r_pc_q  [2];
  logic [31:0] r_ins_q [2];
  logic        w_pop, w_space, w_run, w_halt_hit, w_push;
  // A full FIFO still accepts a fetch when the head is leaving this cycle
  always_comb begin
    w_pop      = dec.out_valid & dec.out_ready;
    w_space    = (r_cnt < 2'd2) | w_pop;
    w_run      = (r_state == RUN) & ~redirect_valid & w_space;
    w_halt_hit = HALT_EN & (douta == HALT_WORD) & w_run;
    w_push     = w_run & ~w_halt_hit;
    w_next     = redirect_valid ? RUN : w_halt_hit ? HALTED : r_state;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_cnt   <= 2'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_pc_q  <= '{default: '0};
      r_ins_q <= '{default: '0};
    end else if (redirect_valid) begin
      r_pc  <= {redirect_pc[31:2], 2'b00};
      r_cnt <= 2'd0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc_q[r_wr]  <= r_pc;
        r_ins_q[r_wr] <= douta;
        r_pc          <= r_pc + 32'd4;
        r_wr          <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  assign addra         = r_pc[ADDR_W+1:2];
  assign dec.out_valid = (r_cnt != 2'd0);
  assign dec.out_instr = r_ins_q[r_rd];
  assign dec.out_pc    = r_pc_q[r_rd];
  assign halted        = (r_state == HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with a scoreboard queue checked by a beat monitor
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addra;
  logic [31:0] douta = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  int          pass_cnt = 0;
  int          total    = 0;
  logic [63:0] exp_q [$];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .addra          (addra),
    .douta          (douta),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (bus),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return (a == 6'd0)  ? 32'he3a00004 :
           (a == 6'd1)  ? 32'he3a01001 :
           (a == 6'd15) ? 32'h0000_0000 : (32'ha000_0000 | {26'd0, a});
  endfunction

  always @(negedge clk) douta <= rom_word(addra);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_beat(input logic [31:0] pc);
    exp_q.push_back({pc, rom_word(pc[7:2])});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got pc %h instr %h expected none", bus.out_pc, bus.out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("beat_pc", bus.out_pc, e[63:32]);
        chk("beat_instr", bus.out_instr, e[31:0]);
      end
    end

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step(3);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addra", {26'd0, addra}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    expect_beat(32'h0);
    expect_beat(32'h4);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(5);
    chk("stall_addra", {26'd0, addra}, 32'd2);
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_head_pc", bus.out_pc, 32'h0);
    chk("stall_head_instr", bus.out_instr, 32'he3a00004);
    expect_beat(32'h0);
    expect_beat(32'h4);
    expect_beat(32'h8);
    bus.out_ready = 1'b1;
    step(3);
    bus.out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h33;
    step(1);
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_addra", {26'd0, addra}, 32'd12);
    expect_beat(32'h30);
    expect_beat(32'h34);
    expect_beat(32'h38);
    bus.out_ready = 1'b1;
    step(5);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_addra", {26'd0, addra}, 32'd15);
    chk("halt_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("unhalt_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("unhalt_addra", {26'd0, addra}, 32'd0);
    step(1);
    chk("unhalt_beat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("unhalt_beat_pc", bus.out_pc, 32'h0);
    step(2);
    chk("refill_addra", {26'd0, addra}, 32'd2);
    expect_beat(32'h0);
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h104;
    step(1);
    redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("popredir_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("popredir_addra", {26'd0, addra}, 32'd1);
    step(1);
    chk("wrap_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("wrap_pc", bus.out_pc, 32'h104);
    chk("wrap_instr", bus.out_instr, 32'he3a01001);
    redirect_valid = 1'b1;
    redirect_pc = 32'h38;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    chk("halt2_halted", {31'd0, halted}, 32'd1);
    chk("halt2_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("halt2_pc", bus.out_pc, 32'h38);
    chk("halt2_addra", {26'd0, addra}, 32'd15);
    rst = 1'b1;
    step(1);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_addra", {26'd0, addra}, 32'd0);
    rst = 1'b0;
    step(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
